// File: rtl/regfile_fwd_sb_pkg.sv
// rtl/regfile_fwd_sb_pkg.sv - shared core configuration for the forwarding register file
package pkg_core_cfg;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;

    // Forwarding stage indices after ID
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // Where a read port takes its value from
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_FWD   = 2'd1,
        SRC_WB    = 2'd2,
        SRC_ARRAY = 2'd3
    } rd_src_e;

    // Width of an age field able to hold 0..nfwd-1
    function automatic int age_width(input int nfwd);
        return (nfwd > 1) ? $clog2(nfwd) : 1;
    endfunction

    // Read priority: r0, then an in-flight writer, then the same-cycle write-back, then the array
    function automatic rd_src_e pick_src(input logic is_zero, input logic fwd_hit, input logic wb_hit);
        if (is_zero) begin
            return SRC_ZERO;
        end else if (fwd_hit) begin
            return SRC_FWD;
        end else if (wb_hit) begin
            return SRC_WB;
        end
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_fwd_sb_if.sv
// rtl/regfile_fwd_sb_if.sv - issue, write-back and read bus between ID and the register file
interface regfile_fwd_sb_if #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 3,
    parameter int NFWD = 3
);
    logic                wen;
    logic [AW-1:0]       waddr;
    logic [DW-1:0]       wdata;
    logic                issue_valid;
    logic [AW-1:0]       issue_dst;
    logic                issue_is_load;
    logic                kill_ex;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_use;
    logic [NFWD*DW-1:0]  stage_data;
    logic [NRD*DW-1:0]   rd_data;
    logic                stall;
    logic [31:0]         stall_cycles;
    logic [NREG*DW-1:0]  dbg_regs;

    modport master (
        output wen, waddr, wdata, issue_valid, issue_dst, issue_is_load, kill_ex,
               rd_addr, rd_use, stage_data,
        input  rd_data, stall, stall_cycles, dbg_regs
    );

    modport slave (
        input  wen, waddr, wdata, issue_valid, issue_dst, issue_is_load, kill_ex,
               rd_addr, rd_use, stage_data,
        output rd_data, stall, stall_cycles, dbg_regs
    );
endinterface

// File: rtl/regfile_fwd_sb_sb_entry.sv
// rtl/regfile_fwd_sb_sb_entry.sv - scoreboard state for one architectural register
module sb_entry
    import pkg_core_cfg::*;
#(
    parameter int NFWD = 3,
    parameter int AGW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           issue,
    input  logic           issue_is_load,
    input  logic           kill_ex,
    output logic           valid,
    output logic [AGW-1:0] age,
    output logic           is_load
);

    // A new issue beats a squash; a squash only hits the EX-age writer; the WB-age writer retires
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            age     <= '0;
            is_load <= 1'b0;
        end else if (issue) begin
            valid   <= 1'b1;
            age     <= '0;
            is_load <= issue_is_load;
        end else if (valid) begin
            if ((kill_ex && age == AGW'(STG_EX)) || age == AGW'(NFWD - 1)) begin
                valid <= 1'b0;
                age   <= '0;
            end else begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_fwd_sb.sv
// rtl/regfile_fwd_sb.sv - register file with per-register scoreboard, forwarding and load-use stall
module regfile_fwd_sb
    import pkg_core_cfg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int NREG       = NREG_DEF,
    parameter int AW         = $clog2(NREG),
    parameter int NRD        = 3,
    parameter int NFWD       = 3,
    parameter int LOAD_STAGE = STG_MEM
) (
    input  logic           clk,
    input  logic           reset,
    regfile_fwd_sb_if.slave bus
);

    localparam int AGW = age_width(NFWD);

    logic [DW-1:0]       regs [NREG];
    logic [DW-1:0]       stg  [NFWD];
    logic [NREG-1:0]     ent_valid;
    logic [NREG-1:0]     ent_load;
    logic [NREG*AGW-1:0] ent_age;
    logic                stall_c;
    logic                issue_ok;
    logic [31:0]         stall_cnt;
    logic [NRD*DW-1:0]   rd_data_c;
    logic [NREG*DW-1:0]  dbg_c;

    // Register 0 never has an in-flight writer
    assign ent_valid[0]     = 1'b0;
    assign ent_load[0]      = 1'b0;
    assign ent_age[AGW-1:0] = '0;

    // Stalled instructions stay in ID, so they must not claim a scoreboard entry
    assign issue_ok = bus.issue_valid && !stall_c && (bus.issue_dst != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        sb_entry #(
            .NFWD (NFWD),
            .AGW  (AGW)
        ) u_ent (
            .clk           (clk),
            .reset         (reset),
            .issue         (issue_ok && (bus.issue_dst == AW'(r))),
            .issue_is_load (bus.issue_is_load),
            .kill_ex       (bus.kill_ex),
            .valid         (ent_valid[r]),
            .age           (ent_age[r*AGW +: AGW]),
            .is_load       (ent_load[r])
        );
    end

    // Unpack the per-stage result bus so it can be indexed by entry age
    always_comb begin
        for (int s = 0; s < NFWD; s++) begin
            stg[s] = bus.stage_data[s*DW +: DW];
        end
    end

    // A consumed operand whose youngest writer is a load not yet at LOAD_STAGE forces a hold
    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        stall_c = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            a = bus.rd_addr[p*AW +: AW];
            if (bus.rd_use[p] && ent_valid[a] && ent_load[a] &&
                (int'(ent_age[int'(a)*AGW +: AGW]) < LOAD_STAGE)) begin
                stall_c = 1'b1;
            end
        end
    end

    // Per-port operand select: zero, forwarded stage, same-cycle write-back, or array
    always_comb begin
        logic [AW-1:0] a;
        rd_src_e       src;
        a         = '0;
        src       = SRC_ARRAY;
        rd_data_c = '0;
        for (int p = 0; p < NRD; p++) begin
            a   = bus.rd_addr[p*AW +: AW];
            src = pick_src(a == '0, ent_valid[a], bus.wen && (bus.waddr == a));
            case (src)
                SRC_ZERO:  rd_data_c[p*DW +: DW] = '0;
                SRC_FWD:   rd_data_c[p*DW +: DW] = stg[ent_age[int'(a)*AGW +: AGW]];
                SRC_WB:    rd_data_c[p*DW +: DW] = bus.wdata;
                default:   rd_data_c[p*DW +: DW] = regs[a];
            endcase
        end
    end

    // Architectural array update from WB; register 0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (bus.wen && (bus.waddr != '0)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Saturating count of cycles spent holding ID
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Flatten the array for observation, forcing register 0 to read as zero
    always_comb begin
        dbg_c = '0;
        for (int r = 1; r < NREG; r++) begin
            dbg_c[r*DW +: DW] = regs[r];
        end
    end

    assign bus.rd_data      = rd_data_c;
    assign bus.stall        = stall_c;
    assign bus.stall_cycles = stall_cnt;
    assign bus.dbg_regs     = dbg_c;

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// tb/tb_regfile_fwd_sb.sv - self-checking bench for regfile_fwd_sb
module tb_regfile_fwd_sb;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 3;
    localparam int NFWD = 3;
    localparam int LS   = 1;

    logic clk;
    logic reset;

    regfile_fwd_sb_if #(.DW(DW), .NREG(NREG), .AW(AW), .NRD(NRD), .NFWD(NFWD)) bus ();

    regfile_fwd_sb #(
        .DW(DW), .NREG(NREG), .AW(AW), .NRD(NRD), .NFWD(NFWD), .LOAD_STAGE(LS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: issue timestamp of the youngest writer per register
    int          cyc = 0;
    bit          started = 1'b0;
    int          m_iss [NREG];
    bit          m_ld  [NREG];
    logic [31:0] m_regs [NREG];
    logic [31:0] m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_age(input int r);
        int a;
        a = cyc - m_iss[r];
        if (a < 0 || a > NFWD - 1) return -1;
        return a;
    endfunction

    function automatic bit exp_stall();
        int a;
        int ag;
        for (int p = 0; p < NRD; p++) begin
            a  = int'(bus.rd_addr[p*AW +: AW]);
            ag = m_age(a);
            if (bus.rd_use[p] && a != 0 && ag >= 0 && m_ld[a] && ag < LS) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(input int a);
        int ag;
        ag = m_age(a);
        if (a == 0) return 32'h0;
        if (ag >= 0) return bus.stage_data[ag*DW +: DW];
        if (bus.wen && int'(bus.waddr) == a) return bus.wdata;
        return m_regs[a];
    endfunction

    // Model update at each edge from the inputs that were applied during the cycle
    initial begin
        bit st;
        bit iss;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int r = 0; r < NREG; r++) begin
                    m_iss[r]  = -100;
                    m_ld[r]   = 1'b0;
                    m_regs[r] = 32'h0;
                end
                m_stalls = 32'h0;
                started  = 1'b1;
                cyc++;
            end else if (started) begin
                st  = exp_stall();
                iss = bus.issue_valid && !st && bus.issue_dst != '0;
                if (bus.kill_ex) begin
                    for (int r = 0; r < NREG; r++) begin
                        if (m_age(r) == 0) m_iss[r] = -100;
                    end
                end
                if (bus.wen && bus.waddr != '0) m_regs[bus.waddr] = bus.wdata;
                if (st && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
                cyc++;
                if (iss) begin
                    m_iss[bus.issue_dst] = cyc;
                    m_ld[bus.issue_dst]  = bus.issue_is_load;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int p = 0; p < NRD; p++) begin
                    chk($sformatf("rd_data[%0d]", p), bus.rd_data[p*DW +: DW],
                        exp_rd(int'(bus.rd_addr[p*AW +: AW])));
                end
                chk("stall", {31'h0, bus.stall}, {31'h0, exp_stall()});
                chk("stall_cycles", bus.stall_cycles, m_stalls);
                for (int r = 0; r < NREG; r++) begin
                    if (bus.dbg_regs[r*DW +: DW] !== m_regs[r]) begin
                        chk($sformatf("dbg_regs[%0d]", r), bus.dbg_regs[r*DW +: DW], m_regs[r]);
                    end
                end
                checks++;
            end
        end
    end

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_dst     = '0;
        bus.issue_is_load = 1'b0;
        bus.kill_ex       = 1'b0;
        bus.wen           = 1'b0;
        bus.waddr         = '0;
        bus.wdata         = '0;
        bus.rd_use        = '0;
        bus.rd_addr       = '0;
        bus.stage_data    = '0;
    endtask

    task automatic set_rd(input int p, input int a, input bit u);
        bus.rd_addr[p*AW +: AW] = AW'(a);
        bus.rd_use[p]           = u;
    endtask

    task automatic set_stg(input int s, input logic [31:0] v);
        bus.stage_data[s*DW +: DW] = v;
    endtask

    task automatic issue(input int d, input bit ld);
        bus.issue_valid   = 1'b1;
        bus.issue_dst     = AW'(d);
        bus.issue_is_load = ld;
    endtask

    task automatic wb(input int a, input logic [31:0] v);
        bus.wen   = 1'b1;
        bus.waddr = AW'(a);
        bus.wdata = v;
        set_stg(NFWD - 1, v);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [31:0] rdp(input int p);
        return bus.rd_data[p*DW +: DW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cleared state
        set_rd(0, 5, 1'b1);
        set_stg(0, 32'h77);
        @(negedge clk);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_cnt", bus.stall_cycles, 32'h0);
        chk("rst_rd5", rdp(0), 32'h0);
        next();

        // ALU back-to-back through EX, MEM, WB and then the array
        issue(5, 1'b0);
        next();
        set_rd(0, 5, 1'b1); set_stg(0, 32'h1234); set_stg(1, 32'h5555);
        @(negedge clk);
        chk("alu_ex", rdp(0), 32'h1234);
        chk("alu_stall", {31'h0, bus.stall}, 32'h0);
        next();
        set_rd(0, 5, 1'b1); set_stg(0, 32'hDEAD); set_stg(1, 32'h1234);
        @(negedge clk);
        chk("alu_mem", rdp(0), 32'h1234);
        next();
        wb(5, 32'h1234); set_stg(1, 32'h9999); set_rd(0, 5, 1'b1);
        @(negedge clk);
        chk("alu_wb", rdp(0), 32'h1234);
        next();
        set_rd(0, 5, 1'b1); set_stg(0, 32'h4444);
        @(negedge clk);
        chk("alu_arr", rdp(0), 32'h1234);
        chk("alu_dbg5", bus.dbg_regs[5*DW +: DW], 32'h1234);
        next();

        // Load-use: one stall cycle; an issue during the stall is not accepted
        issue(8, 1'b1);
        next();
        set_rd(1, 8, 1'b1); set_stg(0, 32'hAAAA); issue(10, 1'b0);
        @(negedge clk);
        chk("lu_stall", {31'h0, bus.stall}, 32'h1);
        chk("lu_cnt0", bus.stall_cycles, 32'h0);
        next();
        set_rd(1, 8, 1'b1); set_stg(1, 32'h8888); set_stg(0, 32'hBBBB); set_rd(2, 10, 1'b1);
        @(negedge clk);
        chk("lu_nostall", {31'h0, bus.stall}, 32'h0);
        chk("lu_cnt1", bus.stall_cycles, 32'h1);
        chk("lu_fwd", rdp(1), 32'h8888);
        chk("lu_noissue", rdp(2), 32'h0);
        next();
        wb(8, 32'h8888);
        next();

        // Youngest writer wins
        issue(3, 1'b0);
        next();
        issue(3, 1'b0);
        next();
        set_rd(0, 3, 1'b1); set_stg(0, 32'hB0B0); set_stg(1, 32'hA0A0);
        @(negedge clk);
        chk("yw_ex", rdp(0), 32'hB0B0);
        next();
        wb(3, 32'hA0A0); set_stg(1, 32'hB0B0); set_rd(0, 3, 1'b1);
        @(negedge clk);
        chk("yw_mem", rdp(0), 32'hB0B0);
        next();
        wb(3, 32'hB0B0);
        next();
        set_rd(0, 3, 1'b1);
        @(negedge clk);
        chk("yw_arr", rdp(0), 32'hB0B0);
        next();

        // Squash of an EX load, with a coinciding issue that survives
        issue(9, 1'b1);
        next();
        bus.kill_ex = 1'b1; issue(11, 1'b0);
        next();
        set_rd(0, 9, 1'b1); set_rd(1, 11, 1'b1); set_stg(0, 32'h1111); set_stg(1, 32'h9A9A);
        @(negedge clk);
        chk("sq_stall", {31'h0, bus.stall}, 32'h0);
        chk("sq_rd9", rdp(0), 32'h0);
        chk("sq_rd11", rdp(1), 32'h1111);
        next();

        // Squash leaves an older (MEM-age) writer alone
        issue(13, 1'b0);
        next();
        next();
        bus.kill_ex = 1'b1;
        next();
        set_rd(0, 13, 1'b1); set_stg(2, 32'h1313);
        @(negedge clk);
        chk("kill_age1", rdp(0), 32'h1313);
        next();
        next();

        // Same-cycle write-back bypass and register 0
        wb(12, 32'hCAFE); set_rd(0, 12, 1'b1);
        @(negedge clk);
        chk("wr_byp", rdp(0), 32'hCAFE);
        next();
        wb(0, 32'hFFFF); set_rd(2, 0, 1'b1);
        @(negedge clk);
        chk("r0_byp", rdp(2), 32'h0);
        next();
        set_rd(0, 12, 1'b1); set_rd(2, 0, 1'b1);
        @(negedge clk);
        chk("wr_arr", rdp(0), 32'hCAFE);
        chk("r0_arr", rdp(2), 32'h0);
        chk("dbg0", bus.dbg_regs[DW-1:0], 32'h0);
        next();

        // Reset with writers still in flight
        issue(20, 1'b0);
        next();
        issue(21, 1'b1);
        next();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        set_rd(0, 20, 1'b1); set_rd(1, 21, 1'b1); set_stg(0, 32'h2020); set_stg(1, 32'h2121);
        @(negedge clk);
        chk("rm_stall", {31'h0, bus.stall}, 32'h0);
        chk("rm_cnt", bus.stall_cycles, 32'h0);
        chk("rm_rd20", rdp(0), 32'h0);
        chk("rm_rd21", rdp(1), 32'h0);
        chk("rm_dbg8", bus.dbg_regs[8*DW +: DW], 32'h0);
        chk("rm_dbg12", bus.dbg_regs[12*DW +: DW], 32'h0);
        next();
        next();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_fwd_sb.md
Name: regfile_fwd_sb

Overview:
- Parametrised register file with a per-register scoreboard for the in-order pipelined core.
- Tracks in-flight writers by pipeline age and forwards results from any tracked stage to NRD read ports.
- Raises a stall for load-use hazards, supports an EX-stage squash, and exposes a saturating stall-cycle counter.
- Sits in ID; generalises fixed-depth 3-port forwarding to arbitrary width, depth, port count and load latency.

Parameters:
- DW, 32, data width.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, $clog2(NREG), register address width (derived).
- NRD, 3, number of read ports.
- NFWD, 3, forwarding stages after ID: index 0 = EX, NFWD-1 = WB.
- LOAD_STAGE, 1, first stage index whose stage_data carries valid load data; 1 <= LOAD_STAGE <= NFWD-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wen  in  1  write-back enable.
- waddr  in  AW  write-back register.
- wdata  in  DW  write-back data; equals stage_data slice NFWD-1.
- issue_valid  in  1  ID instruction writes a register.
- issue_dst  in  AW  destination of the issuing instruction.
- issue_is_load  in  1  issuing instruction is a load.
- kill_ex  in  1  squash the instruction currently in EX (branch flush).
- rd_addr  in  NRD*AW  read addresses, port p at slice p.
- rd_use  in  NRD  port p value is consumed this cycle.
- stage_data  in  NFWD*DW  result bus of each stage, slice s = stage s.
- rd_data  out  NRD*DW  forwarded read data.
- stall  out  1  load-use hazard; ID must hold.
- stall_cycles  out  32  saturating count of stalled cycles.
- dbg_regs  out  NREG*DW  architectural register contents.

Behaviour:
- Reset (synchronous): all registers 0, all scoreboard entries invalid, stall_cycles 0; rd_data and stall are combinational on the cleared state.
- Scoreboard entry per register: valid, age (0..NFWD-1), is_load.
- Issue: accepted when issue_valid && !stall && issue_dst != 0. At the edge the entry becomes valid, age 0, is_load = issue_is_load. A new issue overwrites any older entry for the same register, so the youngest writer wins.
- Ageing: every edge, each valid entry not being issued increments its age. An entry at age NFWD-1 becomes invalid at the next edge, the same edge on which WB writes the array.
- kill_ex: at the edge, entries with age 0 are invalidated before ageing. If kill_ex and an accepted issue coincide, the new issue is kept.
- Array write: on wen && waddr != 0, at the edge. Register 0 always reads 0.
- Read mux per port, in priority order:
  - addr 0 gives 0.
  - A valid entry gives stage_data[age].
  - wen && waddr == addr gives wdata.
  - Otherwise the array value.
  - Purely combinational; 0-cycle latency.
- stall: asserted when, for any p, rd_use[p] && the entry for rd_addr[p] is valid && is_load && age < LOAD_STAGE. Combinational, independent of issue_valid.
- stall_cycles: increments on each cycle with stall high; saturates at 32'hFFFF_FFFF.
- Stage pipeline registers are owned upstream. With stall high the EX bubble is inserted upstream; ageing continues unconditionally.
- Reset mid-operation: all pending entries are discarded; no forwarding on the first cycle after reset.

Decomposition:
- Shared package pkg_core_cfg holds DW/NREG defaults and the stage index constants STG_EX=0, STG_MEM=1, STG_WB=2.
- One sub-module, sb_entry: holds one register's valid/age/is_load state, with issue/kill/age logic. Instantiated NREG-1 times through a generate loop.

Test Plan:
- ALU back-to-back:
  - Issue dst=5 (non-load).
  - Next cycle read port0 addr 5 with stage_data[0]=32'h1234 → rd_data[0]=32'h1234, stall=0.
  - Following cycle stage_data[1]=32'h1234 → forwarded from MEM.
- Load-use:
  - Issue load dst=8.
  - Next cycle rd_use[1]=1, rd_addr[1]=8 → stall=1 for one cycle, stall_cycles=1.
  - Following cycle stall=0 and rd_data[1]=stage_data[1].
- Youngest wins:
  - Issue dst=3 (value A), then next cycle dst=3 (value B).
  - Read 3 → stage_data[0] (B), not stage_data[1] (A).
  - After both retire, array[3]=B.
- Squash:
  - Issue load dst=9, then assert kill_ex the next cycle.
  - Read 9 → array value, stall=0.
- Write/read same cycle and r0:
  - wen=1, waddr=12, wdata=32'hCAFE with no entry; read 12 → 32'hCAFE.
  - Write to 0 with 32'hFFFF; read 0 → 0.
- Reset:
  - After several pending issues, assert reset for one cycle.
  - All dbg_regs=0, stall=0, stall_cycles=0, reads return 0.
